// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared constants and state encoding for the SRAM arbiter.
package sram_arb_pkg;

   localparam int unsigned ACCESS_CYCLES_DEF = 6;
   localparam int unsigned ADDR_W_DEF        = 15;
   localparam int unsigned DATA_W_DEF        = 8;

   // Wide enough for the largest legal ACCESS_CYCLES-1 (14)
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/sram_arb_sel.sv
// sram_arb_sel: picks one of two requesters; ptr_i=1 favours client 1 on a tie.
module sram_arb_sel (
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   output logic [1:0] grant_c_o
);

   // One-hot winner; a lone requester always wins, a tie goes to the pointer
   always_comb begin
      grant_c_o = 2'b00;
      if (req_i == 2'b11) begin
         grant_c_o = ptr_i ? 2'b10 : 2'b01;
      end else if (req_i[0]) begin
         grant_c_o = 2'b01;
      end else if (req_i[1]) begin
         grant_c_o = 2'b10;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-client front end for a single-port SRAM controller,
// one access outstanding at a time (IDLE -> ISSUE -> BUSY -> DONE).
// Build option SRAM_ARB_RR_EN: round-robin on simultaneous requests;
// without it client 0 has fixed priority.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEF,
   parameter int unsigned ADDR_W        = ADDR_W_DEF,
   parameter int unsigned DATA_W        = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c0_req,
   input  logic              c0_we,
   input  logic [ADDR_W-1:0] c0_addr,
   input  logic [DATA_W-1:0] c0_wdata,
   output logic              c0_ack,
   output logic [DATA_W-1:0] c0_rdata,
   input  logic              c1_req,
   input  logic              c1_we,
   input  logic [ADDR_W-1:0] c1_addr,
   input  logic [DATA_W-1:0] c1_wdata,
   output logic              c1_ack,
   output logic [DATA_W-1:0] c1_rdata,
   output logic              sram_wreq,
   output logic              sram_rreq,
   output logic [ADDR_W-1:0] sram_waddr,
   output logic [ADDR_W-1:0] sram_raddr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                gnt_q, gnt_d;
   logic                we_q, we_d;
   logic                ack0_q, ack0_d, ack1_q, ack1_d;
   logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic                wreq_q, wreq_d, rreq_q, rreq_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d, raddr_q, raddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;

   logic [1:0]          req_c, grant_c;
   logic                ptr_c, start_c, sel_we_c;
   logic [ADDR_W-1:0]   sel_addr_c;
   logic [DATA_W-1:0]   sel_wdata_c;

   assign req_c = {c1_req, c0_req};

   sram_arb_sel u_sel (
      .req_i     (req_c),
      .ptr_i     (ptr_c),
      .grant_c_o (grant_c)
   );

`ifdef SRAM_ARB_RR_EN
   logic ptr_q;

   // Favour the client that did not win the most recent grant
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= 1'b0;
      end else if (start_c) begin
         ptr_q <= grant_c[0];
      end
   end

   assign ptr_c = ptr_q;
`else
   assign ptr_c = 1'b0;
`endif

   // A new access may start from IDLE or straight out of the ack cycle
   assign start_c     = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && (|grant_c);
   assign sel_we_c    = grant_c[1] ? c1_we    : c0_we;
   assign sel_addr_c  = grant_c[1] ? c1_addr  : c0_addr;
   assign sel_wdata_c = grant_c[1] ? c1_wdata : c0_wdata;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_c) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_BUSY;
         ST_BUSY:  if (cnt_q == '0) state_d = ST_DONE;
         ST_DONE:  state_d = start_c ? ST_ISSUE : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output/datapath next values; registered so every output is a flop
   always_comb begin
      cnt_d    = cnt_q;
      gnt_d    = gnt_q;
      we_d     = we_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      wreq_d   = 1'b0;
      rreq_d   = 1'b0;
      waddr_d  = waddr_q;
      raddr_d  = raddr_q;
      wdata_d  = wdata_q;
      case (state_q)
         ST_ISSUE: cnt_d = CNT_W'(ACCESS_CYCLES - 1);
         ST_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               // Ack and read data land together in the DONE cycle
               ack0_d = ~gnt_q;
               ack1_d = gnt_q;
               if (!we_q) begin
                  if (gnt_q) rdata1_d = sram_rdata;
                  else       rdata0_d = sram_rdata;
               end
            end
         end
         ST_DONE: begin
            waddr_d = '0;
            raddr_d = '0;
            wdata_d = '0;
         end
         default: ;
      endcase
      if (start_c) begin
         gnt_d   = grant_c[1];
         we_d    = sel_we_c;
         wreq_d  = sel_we_c;
         rreq_d  = ~sel_we_c;
         waddr_d = sel_we_c ? sel_addr_c  : '0;
         raddr_d = sel_we_c ? '0          : sel_addr_c;
         wdata_d = sel_we_c ? sel_wdata_c : '0;
      end
   end

   // Datapath and output registers; reset aborts any access silently
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         gnt_q    <= 1'b0;
         we_q     <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         wreq_q   <= 1'b0;
         rreq_q   <= 1'b0;
         waddr_q  <= '0;
         raddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         we_q     <= we_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         wreq_q   <= wreq_d;
         rreq_q   <= rreq_d;
         waddr_q  <= waddr_d;
         raddr_q  <= raddr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign c0_ack     = ack0_q;
   assign c1_ack     = ack1_q;
   assign c0_rdata   = rdata0_q;
   assign c1_rdata   = rdata1_q;
   assign sram_wreq  = wreq_q;
   assign sram_rreq  = rreq_q;
   assign sram_waddr = waddr_q;
   assign sram_raddr = raddr_q;
   assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vectors, corner sequences and random traffic,
// all cross-checked every cycle against a transaction-timing model.
module tb_sram_arbiter;

   localparam int unsigned A  = 6;
   localparam int unsigned AW = 15;
   localparam int unsigned DW = 8;
`ifdef SRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]    req_v = 2'b00;
   logic [1:0]    we_v  = 2'b00;
   logic [AW-1:0] addr_v  [2];
   logic [DW-1:0] wdata_v [2];
   logic          c0_ack, c1_ack, sram_wreq, sram_rreq;
   logic [DW-1:0] c0_rdata, c1_rdata, sram_wdata, sram_rdata;
   logic [AW-1:0] sram_waddr, sram_raddr;
   logic [1:0]    ack_v;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   assign ack_v      = {c1_ack, c0_ack};
   assign sram_rdata = mem[sram_raddr];

   sram_arbiter #(.ACCESS_CYCLES(A), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .c0_req(req_v[0]), .c0_we(we_v[0]), .c0_addr(addr_v[0]), .c0_wdata(wdata_v[0]),
      .c0_ack(c0_ack), .c0_rdata(c0_rdata),
      .c1_req(req_v[1]), .c1_we(we_v[1]), .c1_addr(addr_v[1]), .c1_wdata(wdata_v[1]),
      .c1_ack(c1_ack), .c1_rdata(c1_rdata),
      .sram_wreq(sram_wreq), .sram_rreq(sram_rreq),
      .sram_waddr(sram_waddr), .sram_raddr(sram_raddr), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata)
   );

   // Controller model: write commits at the edge ending the request pulse
   always @(posedge clk) if (sram_wreq) mem[sram_waddr] <= sram_wdata;

   int n_chk = 0;
   int n_pass = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endfunction

   // ---------------- reference model (transaction timing) ----------------
   int unsigned   cyc = 0, issue_cyc = 0, ack_cyc = 0;
   bit            outst = 1'b0, last_win = 1'b1, m_we = 1'b0;
   int            owner = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0, m_rd = '0;
   logic [DW-1:0] exp_rd [2] = '{8'h00, 8'h00};
   logic [DW-1:0] ref_mem [int unsigned];

   // Decide at each edge whether a grant happens and when it completes
   always @(posedge clk) begin
      int w;
      if (rst) begin
         if (outst && cyc == ack_cyc) outst = 1'b0;
         if (!outst && req_v != 2'b00) begin
            if (req_v == 2'b11) w = (RR && !last_win) ? 1 : 0;
            else                w = req_v[0] ? 0 : 1;
            last_win  = (w == 1);
            owner     = w;
            outst     = 1'b1;
            m_we      = we_v[w];
            m_addr    = addr_v[w];
            m_wdata   = wdata_v[w];
            issue_cyc = cyc + 1;
            ack_cyc   = cyc + A + 2;
            if (m_we) ref_mem[int'(m_addr)] = m_wdata;
            else      m_rd = ref_mem.exists(int'(m_addr)) ? ref_mem[int'(m_addr)] : 8'h00;
         end
      end
      cyc++;
   end

   // Compare every output mid-cycle against the model
   always @(negedge clk) begin
      bit act, ack_now;
      if (!rst) begin
         outst = 1'b0; last_win = 1'b1; exp_rd[0] = '0; exp_rd[1] = '0;
      end
      act     = rst && outst;
      ack_now = act && (cyc == ack_cyc);
      if (ack_now && !m_we) exp_rd[owner] = m_rd;
      chk("m_wreq",  32'(sram_wreq),  32'(act && cyc == issue_cyc && m_we));
      chk("m_rreq",  32'(sram_rreq),  32'(act && cyc == issue_cyc && !m_we));
      chk("m_waddr", 32'(sram_waddr), (act && m_we)  ? 32'(m_addr)  : 32'd0);
      chk("m_raddr", 32'(sram_raddr), (act && !m_we) ? 32'(m_addr)  : 32'd0);
      chk("m_wdata", 32'(sram_wdata), (act && m_we)  ? 32'(m_wdata) : 32'd0);
      chk("m_ack0",  32'(c0_ack),     32'(ack_now && owner == 0));
      chk("m_ack1",  32'(c1_ack),     32'(ack_now && owner == 1));
      chk("m_rd0",   32'(c0_rdata),   32'(exp_rd[0]));
      chk("m_rd1",   32'(c1_rdata),   32'(exp_rd[1]));
   end

   // ---------------- stimulus ----------------
   typedef struct {
      int            cl;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rd;
   } vec_t;

   vec_t tbl [7];

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ack0"}, 32'(c0_ack), 32'd0);
      chk({tag, "_ack1"}, 32'(c1_ack), 32'd0);
      chk({tag, "_wreq"}, 32'(sram_wreq), 32'd0);
      chk({tag, "_rreq"}, 32'(sram_rreq), 32'd0);
      chk({tag, "_bus"},  32'(sram_waddr | sram_raddr), 32'd0);
      chk({tag, "_wdat"}, 32'(sram_wdata), 32'd0);
      chk({tag, "_rd"},   32'(c0_rdata | c1_rdata), 32'd0);
   endtask

   // One isolated access with hand-derived latency and bus expectations
   task automatic run_vec(input vec_t v);
      bit got = 1'b0;
      req_v[v.cl] = 1'b1; we_v[v.cl] = v.we; addr_v[v.cl] = v.addr; wdata_v[v.cl] = v.wdata;
      for (int k = 1; k <= int'(A) + 6 && !got; k++) begin
         step();
         if (k == 1) begin
            chk("v_wreq", 32'(sram_wreq), 32'(v.we));
            chk("v_rreq", 32'(sram_rreq), 32'(!v.we));
            chk("v_addr", v.we ? 32'(sram_waddr) : 32'(sram_raddr), 32'(v.addr));
            chk("v_other_bus", v.we ? 32'(sram_raddr) : 32'(sram_waddr), 32'd0);
            if (v.we) chk("v_wdata", 32'(sram_wdata), 32'(v.wdata));
         end
         if (ack_v[v.cl]) begin
            got = 1'b1;
            chk("v_ack_latency", 32'(k), 32'(A + 2));
            chk("v_no_other_ack", 32'(ack_v[1 - v.cl]), 32'd0);
            if (!v.we) chk("v_rdata", v.cl == 1 ? 32'(c1_rdata) : 32'(c0_rdata), 32'(v.exp_rd));
            req_v[v.cl] = 1'b0;
         end
      end
      if (!got) chk("v_ack_timeout", 32'd0, 32'd1);
      step();
   endtask

   task automatic new_req(input int i);
      req_v[i]   = 1'b1;
      we_v[i]    = 1'($urandom_range(0, 1));
      addr_v[i]  = AW'($urandom_range(0, 31));
      wdata_v[i] = DW'($urandom);
   endtask

   initial begin
      int order [4];
      int exp_order [4];
      int n, t1, t2, nb, n_acks;

      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      addr_v  = '{15'h0, 15'h0};
      wdata_v = '{8'h0, 8'h0};

      tbl[0] = '{0, 1'b1, 15'h0012, 8'hA5, 8'h00};
      tbl[1] = '{1, 1'b1, 15'h7FFF, 8'h3C, 8'h00};
      tbl[2] = '{1, 1'b0, 15'h7FFF, 8'h00, 8'h3C};
      tbl[3] = '{0, 1'b0, 15'h0012, 8'h00, 8'hA5};
      tbl[4] = '{0, 1'b1, 15'h0000, 8'hFF, 8'h00};
      tbl[5] = '{1, 1'b0, 15'h0000, 8'h00, 8'hFF};
      tbl[6] = '{0, 1'b0, 15'h7FFF, 8'h00, 8'h3C};

      // Reset state
      repeat (3) step();
      check_all_zero("reset");
      rst = 1'b1;
      step();

      // Directed single accesses
      for (int i = 0; i < 7; i++) run_vec(tbl[i]);
      repeat (3) step();
      chk("hold_rd0", 32'(c0_rdata), 32'h3C);
      chk("hold_rd1", 32'(c1_rdata), 32'hFF);

      // Contention: both held across four accesses, from a fresh pointer
      rst = 1'b0; step(); rst = 1'b1; step();
      exp_order = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
      we_v = 2'b00; addr_v[0] = 15'h0012; addr_v[1] = 15'h7FFF;
      req_v = 2'b11;
      n = 0;
      for (int cy = 0; cy < 80 && n < 4; cy++) begin
         step();
         if (c0_ack && n < 4) begin order[n] = 0; n++; end
         if (c1_ack && n < 4) begin order[n] = 1; n++; end
         if (n == 4) req_v = 2'b00;
      end
      req_v = 2'b00;
      chk("cont_count", 32'(n), 32'd4);
      for (int i = 0; i < 4 && i < n; i++) chk("cont_order", 32'(order[i]), 32'(exp_order[i]));
      repeat (2) step();

      // Reset in the third BUSY cycle aborts the access without an ack
      req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 15'h0055; wdata_v[0] = 8'h11;
      for (int k = 1; k <= 4; k++) step();
      rst = 1'b0; req_v[0] = 1'b0;
      #1;
      check_all_zero("abort");
      repeat (2) step();
      rst = 1'b1;
      nb = 0;
      for (int k = 0; k < int'(A) + 4; k++) begin step(); nb += int'(c0_ack) + int'(c1_ack); end
      chk("abort_no_ack", 32'(nb), 32'd0);
      run_vec('{0, 1'b1, 15'h0055, 8'h22, 8'h00});
      run_vec('{0, 1'b0, 15'h0055, 8'h00, 8'h22});

      // Back-to-back: request held across the ack cycle
      req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 15'h0100; wdata_v[0] = 8'h77;
      t1 = -1; t2 = -1; nb = 0;
      for (int cy = 1; cy <= 40 && nb < 2; cy++) begin
         step();
         if (sram_wreq) begin
            if (t1 < 0) t1 = cy; else if (t2 < 0) t2 = cy;
         end
         if (c0_ack) begin
            nb++;
            if (nb == 1) wdata_v[0] = 8'h78;
            else         req_v[0] = 1'b0;
         end
      end
      req_v[0] = 1'b0;
      chk("b2b_acks", 32'(nb), 32'd2);
      chk("b2b_gap", 32'(t2 - t1), 32'(A + 2));
      repeat (2) step();

      // Random traffic; the model checks every cycle
      n_acks = 0;
      for (int cy = 0; cy < 3000; cy++) begin
         step();
         for (int i = 0; i < 2; i++) begin
            if (req_v[i] && ack_v[i]) begin
               n_acks++;
               if ($urandom_range(0, 1) == 0) req_v[i] = 1'b0;
               else new_req(i);
            end else if (!req_v[i] && $urandom_range(0, 2) == 0) begin
               new_req(i);
            end
         end
      end
      for (int cy = 0; cy < 300 && req_v != 2'b00; cy++) begin
         step();
         for (int i = 0; i < 2; i++) if (req_v[i] && ack_v[i]) req_v[i] = 1'b0;
      end
      chk("drain", 32'(req_v), 32'd0);
      chk("rand_progress", 32'(n_acks > 100), 32'd1);
      req_v = 2'b00;
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 6, meaning the number of busy cycles held after the SRAM request pulse before completion; legal range 2..15.
REQ-002 SHALL have parameter ADDR_W, default 15, meaning the SRAM address width.
REQ-003 SHALL have parameter DATA_W, default 8, meaning the SRAM data width.
REQ-004 SHALL have port clk  in  1  system clock.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports cN_req  in  1  client N (N=0,1) access request, held until ack.
REQ-007 SHALL have ports cN_we  in  1  client N operation: 1=write, 0=read; stable while cN_req.
REQ-008 SHALL have ports cN_addr  in  ADDR_W  client N address; stable while cN_req.
REQ-009 SHALL have ports cN_wdata  in  DATA_W  client N write data; stable while cN_req.
REQ-010 SHALL have ports cN_ack  out  1  one-cycle completion pulse to client N.
REQ-011 SHALL have ports cN_rdata  out  DATA_W  client N read data; valid in the ack cycle and held until the next read completion for that client.
REQ-012 SHALL have ports sram_wreq / sram_rreq  out  1  one-cycle write / read request to the SRAM controller.
REQ-013 SHALL have ports sram_waddr, sram_raddr  out  ADDR_W, and sram_wdata  out  DATA_W, forming the controller address and data bus.
REQ-014 SHALL have port sram_rdata  in  DATA_W  read data returned by the controller.

Function
REQ-015 SHALL implement the states IDLE, ISSUE, BUSY and DONE.
REQ-016 IDLE SHALL, when any cN_req=1, select a winner and latch its we, addr and wdata plus a grant index, then go to ISSUE; with no request it SHALL stay in IDLE.
REQ-017 ISSUE SHALL last exactly 1 cycle, asserting sram_wreq if we=1 else sram_rreq, and loading the counter with ACCESS_CYCLES-1 -> BUSY.
REQ-018 BUSY SHALL decrement the counter each cycle and exit to DONE in the cycle the counter is 0, giving exactly ACCESS_CYCLES BUSY cycles.
REQ-019 DONE SHALL last 1 cycle, pulse ack of the granted client, load sram_rdata into that client's cN_rdata on a read, then go to IDLE.
REQ-020 For a request sampled at edge E, the SRAM request SHALL be high in cycle E+1 and ack SHALL be high in cycle E+ACCESS_CYCLES+2.
REQ-021 sram_waddr/sram_raddr/sram_wdata SHALL hold the latched values from ISSUE through DONE; only the bus matching the operation is driven, and the other holds 0.
REQ-022 sram_wreq and sram_rreq SHALL never both be high, and neither SHALL be high outside ISSUE.
REQ-023 A cN_req still high at the edge ending its ack cycle SHALL be treated as a new request.
REQ-024 Requests arriving outside IDLE SHALL wait without loss; at most one access SHALL be outstanding.
REQ-025 Both acks SHALL never be high in the same cycle; the non-granted client's outputs SHALL be unaffected.

Reset
REQ-026 rst=0 SHALL force IDLE, counter 0, all outputs 0 and the round-robin pointer to favour client 0, immediately including mid-access; no ack SHALL be issued for an aborted access.

Configuration
REQ-027 With SRAM_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin, i.e. to the client not granted most recently.
REQ-028 Without SRAM_ARB_RR_EN, client 0 SHALL always win simultaneous requests (fixed priority), and the pointer logic SHALL be absent.

Structure
REQ-029 A shared package sram_arb_pkg SHALL hold the state encoding constants and the ADDR_W/DATA_W default constants.
REQ-030 Winner selection SHALL live in sub-module sram_arb_sel (req vector plus pointer in, one-hot grant out).

Verification
REQ-031 Single write: c0 write addr 15'h0012, data 8'hA5 -> sram_wreq high 1 cycle with waddr 0012/wdata A5; c0_ack in cycle E+8 (default).
REQ-032 Write then read: c1 writes 8'h3C to 15'h7FFF, then reads 15'h7FFF with the controller model -> c1_rdata=8'h3C at c1_ack, and held afterwards.
REQ-033 Simultaneous contention, both held for 4 accesses -> with SRAM_ARB_RR_EN grants go 0,1,0,1; without it, c0 is served first every time c0 requests.
REQ-034 Reset mid-BUSY (rst low in the 3rd BUSY cycle) -> all outputs 0 at once, no ack, and a fresh c0 request after release completes normally.
REQ-035 Back-to-back: c0 keeps req high across its ack -> second access issues at the edge ending the ack cycle, so the two sram_wreq pulses are ACCESS_CYCLES+2 cycles apart.
